// File: rtl/touch_adc_responder.sv
// Slave side of a touch-controller ADC link: receives a control byte, answers with a 12- or 8-bit sample.
// Outputs respond 3 cclk after a touch_clk pin edge; chip-select release aborts any frame.
module touch_adc_responder (
    input  logic        cclk,
    input  logic        rstb,
    input  logic        touch_clk,
    input  logic        touch_csb,
    input  logic        touch_din,
    output logic        touch_dout,
    output logic        touch_busy,
    input  logic [11:0] x_val,
    input  logic [11:0] y_val,
    input  logic [11:0] z1_val,
    input  logic [11:0] z2_val,
    output logic [7:0]  ctrl_byte,
    output logic        ctrl_valid
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_CONV = 2'd2;
    localparam logic [1:0] ST_DATA = 2'd3;

    logic [1:0]  clk_sync;
    logic [1:0]  csb_sync;
    logic [1:0]  din_sync;
    logic        clk_dly;
    logic        clk_rise;
    logic        clk_fall;
    logic        csb_s;
    logic        din_s;

    logic [1:0]  state;
    logic [3:0]  bit_cnt;
    logic [6:0]  cmd_sr;
    logic [7:0]  cmd_next;
    logic [11:0] out_sr;
    logic [3:0]  out_len;
    logic [3:0]  out_cnt;
    logic [11:0] sel_val;

    // Synchronizers reset to the idle line levels so no spurious edge follows reset.
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            clk_sync <= 2'b00;
            csb_sync <= 2'b11;
            din_sync <= 2'b00;
            clk_dly  <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], touch_clk};
            csb_sync <= {csb_sync[0], touch_csb};
            din_sync <= {din_sync[0], touch_din};
            clk_dly  <= clk_sync[1];
        end
    end

    assign clk_rise = clk_sync[1] & ~clk_dly;
    assign clk_fall = ~clk_sync[1] & clk_dly;
    assign csb_s    = csb_sync[1];
    assign din_s    = din_sync[1];
    assign cmd_next = {cmd_sr, din_s};

    always_comb begin
        sel_val = 12'h000;
        case (cmd_next[6:4])
            3'b101:  sel_val = x_val;
            3'b001:  sel_val = y_val;
            3'b011:  sel_val = z1_val;
            3'b100:  sel_val = z2_val;
            default: sel_val = 12'h000;
        endcase
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state      <= ST_IDLE;
            bit_cnt    <= 4'd0;
            cmd_sr     <= 7'd0;
            out_sr     <= 12'h000;
            out_len    <= 4'd12;
            out_cnt    <= 4'd0;
            touch_dout <= 1'b0;
            touch_busy <= 1'b0;
            ctrl_byte  <= 8'h00;
            ctrl_valid <= 1'b0;
        end else begin
            ctrl_valid <= 1'b0;
            // Chip-select release beats any coincident clock edge.
            if (csb_s) begin
                state      <= ST_IDLE;
                bit_cnt    <= 4'd0;
                out_cnt    <= 4'd0;
                touch_dout <= 1'b0;
                touch_busy <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (clk_rise && din_s) begin
                            state   <= ST_CMD;
                            bit_cnt <= 4'd1;
                            cmd_sr  <= 7'd1;
                        end
                    end
                    ST_CMD: begin
                        if (clk_rise) begin
                            cmd_sr  <= cmd_next[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                ctrl_byte  <= cmd_next;
                                ctrl_valid <= 1'b1;
                                touch_busy <= 1'b1;
                                bit_cnt    <= 4'd0;
                                state      <= ST_CONV;
                                // 8-bit mode left-aligns the upper byte so shifting stays MSB-first.
                                out_sr     <= cmd_next[3] ? {sel_val[11:4], 4'h0} : sel_val;
                                out_len    <= cmd_next[3] ? 4'd8 : 4'd12;
                            end
                        end
                    end
                    ST_CONV: begin
                        if (clk_fall) begin
                            touch_busy <= 1'b0;
                            touch_dout <= out_sr[11];
                            out_sr     <= {out_sr[10:0], 1'b0};
                            out_cnt    <= 4'd1;
                            state      <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (clk_fall) begin
                            if (out_cnt == out_len) begin
                                touch_dout <= 1'b0;
                                out_cnt    <= 4'd0;
                                state      <= ST_IDLE;
                            end else begin
                                touch_dout <= out_sr[11];
                                out_sr     <= {out_sr[10:0], 1'b0};
                                out_cnt    <= out_cnt + 4'd1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_touch_adc_responder.sv
// Randomized bench for touch_adc_responder with a queue-based frame model and directed literal checks.
module tb_touch_adc_responder;

    logic        cclk = 1'b0;
    logic        rstb = 1'b0;
    logic        touch_clk = 1'b0;
    logic        touch_csb = 1'b1;
    logic        touch_din = 1'b0;
    logic        touch_dout;
    logic        touch_busy;
    logic        ctrl_valid;
    logic [7:0]  ctrl_byte;
    logic [11:0] x_val = 12'h000;
    logic [11:0] y_val = 12'h000;
    logic [11:0] z1_val = 12'h000;
    logic [11:0] z2_val = 12'h000;

    always #5 cclk = ~cclk;

    touch_adc_responder dut (
        .cclk       (cclk),
        .rstb       (rstb),
        .touch_clk  (touch_clk),
        .touch_csb  (touch_csb),
        .touch_din  (touch_din),
        .touch_dout (touch_dout),
        .touch_busy (touch_busy),
        .x_val      (x_val),
        .y_val      (y_val),
        .z1_val     (z1_val),
        .z2_val     (z2_val),
        .ctrl_byte  (ctrl_byte),
        .ctrl_valid (ctrl_valid)
    );

    int vectors = 0;
    int miscompares = 0;
    int valid_cnt = 0;
    int busy_rises = 0;
    bit checking = 1'b0;
    logic busy_prev = 1'b0;
    int h = 5;
    bit rand_din = 1'b0;

    // Reference model: pins seen through a 3-cycle observation delay, frames as bit queues.
    logic [2:0]  mq_clk, mq_csb, mq_din;
    bit          cmd_q[$];
    bit          resp_q[$];
    bit          active;
    logic        m_dout, m_busy, m_valid;
    logic [7:0]  m_ctrl;
    logic        cn, cp, cs, di;
    logic [7:0]  mb;
    logic [11:0] chan[8];
    logic [11:0] sel;

    always @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            mq_clk = 3'b000; mq_csb = 3'b111; mq_din = 3'b000;
            cmd_q.delete(); resp_q.delete(); active = 1'b0;
            m_dout = 1'b0; m_busy = 1'b0; m_valid = 1'b0; m_ctrl = 8'h00;
        end else begin
            cn = mq_clk[1]; cp = mq_clk[2]; cs = mq_csb[1]; di = mq_din[1];
            m_valid = 1'b0;
            if (cs) begin
                cmd_q.delete(); resp_q.delete(); active = 1'b0;
                m_dout = 1'b0; m_busy = 1'b0;
            end else if (!active && cn && !cp) begin
                if (cmd_q.size() > 0 || di) cmd_q.push_back(di);
                if (cmd_q.size() == 8) begin
                    mb = 8'h00;
                    foreach (cmd_q[i]) mb = {mb[6:0], cmd_q[i]};
                    cmd_q.delete();
                    m_ctrl = mb; m_valid = 1'b1; m_busy = 1'b1; active = 1'b1;
                    chan = '{12'h000, y_val, 12'h000, z1_val, z2_val, x_val, 12'h000, 12'h000};
                    sel = chan[mb[6:4]];
                    for (int i = 0; i < (mb[3] ? 8 : 12); i++) resp_q.push_back(sel[11-i]);
                end
            end else if (active && !cn && cp) begin
                m_busy = 1'b0;
                if (resp_q.size() > 0) m_dout = resp_q.pop_front();
                else begin m_dout = 1'b0; active = 1'b0; end
            end
            mq_clk = {mq_clk[1:0], touch_clk};
            mq_csb = {mq_csb[1:0], touch_csb};
            mq_din = {mq_din[1:0], touch_din};
        end
    end

    always @(negedge cclk) begin
        if (checking) begin
            vectors++;
            if (touch_dout !== m_dout || touch_busy !== m_busy || ctrl_valid !== m_valid || ctrl_byte !== m_ctrl) begin
                miscompares++;
                $display("FAIL cycle_cmp t=%0t dout/busy/valid/byte got %b/%b/%b/%h want %b/%b/%b/%h",
                         $time, touch_dout, touch_busy, ctrl_valid, ctrl_byte, m_dout, m_busy, m_valid, m_ctrl);
            end
            if (ctrl_valid === 1'b1) valid_cnt++;
            if (touch_busy === 1'b1 && busy_prev !== 1'b1) busy_rises++;
            busy_prev = touch_busy;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_h();
        repeat (h) @(negedge cclk);
    endtask

    task automatic mutate_vals();
        case ($urandom_range(0, 3))
            0: x_val  = 12'($urandom);
            1: y_val  = 12'($urandom);
            2: z1_val = 12'($urandom);
            default: z2_val = 12'($urandom);
        endcase
    endtask

    // abort_at < 8 raises csb before command bit abort_at; 8..19 raises it during readback.
    task automatic send_frame(input logic [7:0] cmd, input int lead, input int abort_at,
                              input int reset_at, output logic [11:0] rd);
        rd = 12'h000;
        @(negedge cclk);
        touch_csb = 1'b0; touch_clk = 1'b0; touch_din = 1'b0;
        wait_h();
        for (int i = 0; i < lead; i++) begin
            touch_clk = 1'b1; wait_h(); touch_clk = 1'b0; wait_h();
        end
        for (int i = 0; i < 8; i++) begin
            if (i == abort_at) begin
                touch_csb = 1'b1; touch_din = 1'b0; repeat (6) @(negedge cclk);
                return;
            end
            touch_din = cmd[7-i]; wait_h();
            touch_clk = 1'b1; wait_h();
            touch_clk = 1'b0;
        end
        for (int r = 0; r < 12; r++) begin
            touch_din = rand_din ? 1'($urandom) : 1'b0;
            if (rand_din && $urandom_range(0, 3) == 0) mutate_vals();
            wait_h();
            rd = {rd[10:0], touch_dout};
            if (r + 8 == abort_at) begin
                touch_csb = 1'b1; touch_din = 1'b0; repeat (6) @(negedge cclk);
                return;
            end
            if (r == reset_at) begin
                #2 rstb = 1'b0;
                #1;
                check("rst_dout", 32'(touch_dout), 32'd0);
                check("rst_busy", 32'(touch_busy), 32'd0);
                check("rst_ctrl", 32'(ctrl_byte), 32'h00);
                repeat (2) @(negedge cclk);
                touch_csb = 1'b1; touch_clk = 1'b0; touch_din = 1'b0;
                rstb = 1'b1;
                repeat (6) @(negedge cclk);
                return;
            end
            touch_clk = 1'b1; wait_h();
            touch_clk = 1'b0;
        end
        wait_h();
        touch_csb = 1'b1; touch_din = 1'b0;
        repeat (6) @(negedge cclk);
    endtask

    initial begin
        logic [11:0] rd;
        int v0, b0;
        repeat (3) @(negedge cclk);
        check("reset_dout", 32'(touch_dout), 32'd0);
        check("reset_busy", 32'(touch_busy), 32'd0);
        check("reset_ctrl", 32'(ctrl_byte), 32'h00);
        check("reset_valid", 32'(ctrl_valid), 32'd0);
        rstb = 1'b1;
        checking = 1'b1;
        repeat (4) @(negedge cclk);

        x_val = 12'hABC; v0 = valid_cnt; b0 = busy_rises;
        send_frame(8'hD0, 0, 99, 99, rd);
        check("x12_data", 32'(rd), 32'hABC);
        check("x12_ctrl", 32'(ctrl_byte), 32'hD0);
        check("x12_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        check("x12_busy_pulses", 32'(busy_rises - b0), 32'd1);
        check("x12_dout_after", 32'(touch_dout), 32'd0);

        y_val = 12'h5A3;
        send_frame(8'h98, 0, 99, 99, rd);
        check("y8_data", 32'(rd), 32'h5A0);
        check("y8_ctrl", 32'(ctrl_byte), 32'h98);

        z1_val = 12'hFFF;
        send_frame(8'hB0, 2, 99, 99, rd);
        check("z1_lead_data", 32'(rd), 32'hFFF);
        check("z1_lead_ctrl", 32'(ctrl_byte), 32'hB0);

        b0 = busy_rises;
        send_frame(8'hA0, 0, 99, 99, rd);
        check("unmapped_data", 32'(rd), 32'h000);
        check("unmapped_busy_pulses", 32'(busy_rises - b0), 32'd1);

        z2_val = 12'h001; v0 = valid_cnt;
        send_frame(8'hC0, 0, 4, 99, rd);
        check("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("abort_ctrl_kept", 32'(ctrl_byte), 32'hA0);
        send_frame(8'hC0, 0, 99, 99, rd);
        check("z2_data", 32'(rd), 32'h001);

        send_frame(8'hD0, 0, 99, 4, rd);
        check("post_rst_ctrl", 32'(ctrl_byte), 32'h00);
        send_frame(8'hD0, 0, 99, 99, rd);
        check("post_rst_data", 32'(rd), 32'hABC);
        check("post_rst_frame_ctrl", 32'(ctrl_byte), 32'hD0);

        rand_din = 1'b1;
        for (int n = 0; n < 40; n++) begin
            h = $urandom_range(4, 6);
            x_val = 12'($urandom); y_val = 12'($urandom);
            z1_val = 12'($urandom); z2_val = 12'($urandom);
            send_frame({1'b1, 7'($urandom)}, $urandom_range(0, 3),
                       ($urandom_range(0, 4) == 0) ? $urandom_range(0, 19) : 99, 99, rd);
        end
        rand_din = 1'b0;
        repeat (10) @(negedge cclk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
